// File: rtl/channel_pointer_regfile_pkg.sv
// Purpose : shared sizing constants, types and flat-index helper for the channel pointer file.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package channel_pointer_regfile_pkg;

    localparam int NCHAN = 16;
    localparam int NPTR  = 4;
    localparam int PW    = 12;
    localparam int CW    = $clog2(NCHAN);
    localparam int SW    = $clog2(NPTR);
    localparam int IW    = CW + SW;
    localparam int NWORD = NCHAN * NPTR;

    typedef logic [CW-1:0] chan_t;
    typedef logic [SW-1:0] psel_t;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [IW-1:0] idx_t;

    // Channel id in the upper bits, pointer select in the lower bits.
    function automatic idx_t flat_idx(input chan_t chan, input psel_t sel);
        return {chan, sel};
    endfunction

endpackage

// File: rtl/channel_pointer_word.sv
// Purpose : one PW-bit pointer with write/increment update and wrap detect.
// Latency : state updates at posedge; o_nxt is the combinational post-update value.
// Backpressure: none; every enabled update is committed.
//
// Ports:
//   clk, rst  clock, async active-high reset
//   i_we      write enable (wins over i_inc)
//   i_wd      write data
//   i_inc     increment enable
//   o_nxt     value the pointer will hold after the coming edge
//   o_wrap    high when the coming edge increments 'hFFF to 0
module channel_pointer_word
    import channel_pointer_regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_we,
    input  logic [PW-1:0] i_wd,
    input  logic i_inc,
    output logic [PW-1:0] o_nxt,
    output logic o_wrap
);

    ptr_t r_q;

    // A write to the same pointer suppresses the increment and its wrap.
    always_comb begin
        o_nxt  = r_q;
        o_wrap = 1'b0;
        if (i_we) begin
            o_nxt = i_wd;
        end else if (i_inc) begin
            o_nxt  = r_q + 1'b1;
            o_wrap = &r_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= o_nxt;
        end
    end

endmodule

// File: rtl/channel_pointer_regfile.sv
// Purpose : 16 channel x 4 pointer x 12-bit register file, 1 write, 1 increment, 2 read ports.
// Latency : reads 1 cycle (registered), forwarding the post-update value of a same-cycle update.
// Backpressure: none; all ports are accepted every cycle.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   wchanid, pselw, d12, wep      write port
//   rchanid, psel0, psel1         shared read channel, per-port pointer select
//   qp0, qp1                      registered read data
//   inc, incchan, incsel          increment port
//   wrap                          registered pulse on an 'hFFF -> 0 increment
module channel_pointer_regfile
    import channel_pointer_regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] wchanid,
    input  logic [SW-1:0] pselw,
    input  logic [PW-1:0] d12,
    input  logic          wep,
    input  logic [CW-1:0] rchanid,
    input  logic [SW-1:0] psel0,
    input  logic [SW-1:0] psel1,
    output logic [PW-1:0] qp0,
    output logic [PW-1:0] qp1,
    input  logic          inc,
    input  logic [CW-1:0] incchan,
    input  logic [SW-1:0] incsel,
    output logic          wrap
);

    idx_t             w_widx;
    idx_t             w_iidx;
    idx_t             w_r0idx;
    idx_t             w_r1idx;
    logic [NWORD-1:0] w_we;
    logic [NWORD-1:0] w_inc;
    logic [NWORD-1:0] w_wrap;
    ptr_t             w_nxt [NWORD];

    ptr_t r_qp0;
    ptr_t r_qp1;
    logic r_wrap;

    assign w_widx  = flat_idx(wchanid, pselw);
    assign w_iidx  = flat_idx(incchan, incsel);
    assign w_r0idx = flat_idx(rchanid, psel0);
    assign w_r1idx = flat_idx(rchanid, psel1);

    // Enables gate the decode so unknown ids with the enable low select nothing.
    for (genvar gi = 0; gi < NWORD; gi++) begin : g_word
        assign w_we[gi]  = wep && (w_widx == idx_t'(gi));
        assign w_inc[gi] = inc && (w_iidx == idx_t'(gi));

        channel_pointer_word u_word (
            .clk    (clk),
            .rst    (rst),
            .i_we   (w_we[gi]),
            .i_wd   (d12),
            .i_inc  (w_inc[gi]),
            .o_nxt  (w_nxt[gi]),
            .o_wrap (w_wrap[gi])
        );
    end

    // Read muxes select the next-state value, which gives forwarding for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qp0  <= '0;
            r_qp1  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_qp0  <= w_nxt[w_r0idx];
            r_qp1  <= w_nxt[w_r1idx];
            r_wrap <= |w_wrap;
        end
    end

    assign qp0  = r_qp0;
    assign qp1  = r_qp1;
    assign wrap = r_wrap;

endmodule
